// File: rtl/spu_pkg.sv
// Shared definitions for the SPU command dispatcher.
//   - opcode encodings of cmd_op
//   - dispatcher state encoding
//   - bit offsets of the packed cmd_shift field
package spu_pkg;

    localparam logic [1:0] OP_NOP = 2'd0;
    localparam logic [1:0] OP_SM  = 2'd1;
    localparam logic [1:0] OP_LN  = 2'd2;
    localparam logic [1:0] OP_RSV = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CHECK  = 2'd1,
        ST_LAUNCH = 2'd2,
        ST_RUN    = 2'd3
    } spu_state_e;

    // cmd_shift = {shift_input[3:0], exp_shift_output[4:0], shift_output[3:0]}
    localparam int unsigned SHIFT_W       = 13;
    localparam int unsigned SHIFT_OUT_LSB = 0;
    localparam int unsigned SHIFT_EXP_LSB = 4;
    localparam int unsigned SHIFT_IN_LSB  = 9;

endpackage

// File: rtl/spu_cmd_fifo.sv
// Small synchronous command FIFO.
// Ports:
//   core_clk, rst_n      clock, async active-low reset (flushes pointers)
//   push_i / pop_i       push / pop requests; ignored when full / empty
//   data_i / data_o      write data / head-of-queue data
//   full_o / empty_o     occupancy flags
module spu_cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             core_clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic             do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge core_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge core_clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/spu_dispatch.sv
// SPU command front-end: queues commands, launches softmax or layernorm one at
// a time with latched configuration, and muxes the shared gbuf port.
// Ports:
//   core_clk, rst_n                 clock, async active-low reset
//   cmd_*                           command valid/ready interface
//   spu_busy/done/err/done_cnt      upstream status
//   cfg_*                           latched configuration to both units
//   sm_* / ln_*                     unit start/end and gbuf requests
//   gbuf_*                          shared gbuf port
module spu_dispatch
    import spu_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int CMD_DEPTH  = 2
) (
    input  logic                  core_clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [ADDR_WIDTH-1:0] cmd_matrix_y,
    input  logic [ADDR_WIDTH-1:0] cmd_matrix_x,
    input  logic [ADDR_WIDTH-1:0] cmd_im_base,
    input  logic [ADDR_WIDTH-1:0] cmd_om_base,
    input  logic [ADDR_WIDTH-1:0] cmd_ifm_align,
    input  logic [ADDR_WIDTH-1:0] cmd_ofm_align,
    input  logic [12:0]           cmd_shift,
    output logic                  spu_busy,
    output logic                  spu_done,
    output logic                  spu_err,
    output logic [15:0]           spu_done_cnt,
    output logic [ADDR_WIDTH-1:0] cfg_matrix_y,
    output logic [ADDR_WIDTH-1:0] cfg_matrix_x,
    output logic [ADDR_WIDTH-1:0] cfg_im_base,
    output logic [ADDR_WIDTH-1:0] cfg_om_base,
    output logic [ADDR_WIDTH-1:0] cfg_ifm_align,
    output logic [ADDR_WIDTH-1:0] cfg_ofm_align,
    output logic [3:0]            cfg_shift_input,
    output logic [4:0]            cfg_exp_shift_output,
    output logic [3:0]            cfg_shift_output,
    output logic                  sm_start,
    output logic                  ln_start,
    input  logic                  sm_end,
    input  logic                  ln_end,
    input  logic                  sm_ren,
    input  logic                  sm_wen,
    input  logic                  ln_ren,
    input  logic                  ln_wen,
    input  logic [ADDR_WIDTH-1:0] sm_raddr,
    input  logic [ADDR_WIDTH-1:0] sm_waddr,
    input  logic [ADDR_WIDTH-1:0] ln_raddr,
    input  logic [ADDR_WIDTH-1:0] ln_waddr,
    input  logic [DATA_WIDTH-1:0] sm_wdata,
    input  logic [DATA_WIDTH-1:0] ln_wdata,
    output logic                  gbuf_ren,
    output logic                  gbuf_wen,
    output logic [ADDR_WIDTH-1:0] gbuf_raddr,
    output logic [ADDR_WIDTH-1:0] gbuf_waddr,
    output logic [DATA_WIDTH-1:0] gbuf_wdata,
    input  logic [DATA_WIDTH-1:0] gbuf_rdata
);

    localparam int CMD_W = 2 + 6 * ADDR_WIDTH + SHIFT_W;

    spu_state_e            state_q;
    logic [1:0]            op_q;
    logic [ADDR_WIDTH-1:0] my_q, mx_q, im_q, om_q, ifa_q, ofa_q;
    logic [SHIFT_W-1:0]    shift_q;
    logic                  sm_start_q, ln_start_q, done_q, err_q;
    logic [15:0]           done_cnt_q;

    logic [CMD_W-1:0]      fifo_din, fifo_dout;
    logic                  fifo_full, fifo_empty, fifo_pop;
    logic                  cmd_bad, unit_end;

    assign fifo_din = {cmd_op, cmd_matrix_y, cmd_matrix_x, cmd_im_base,
                       cmd_om_base, cmd_ifm_align, cmd_ofm_align, cmd_shift};
    assign fifo_pop = (state_q == ST_IDLE) && !fifo_empty;

    spu_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .core_clk (core_clk),
        .rst_n    (rst_n),
        .push_i   (cmd_valid),
        .pop_i    (fifo_pop),
        .data_i   (fifo_din),
        .data_o   (fifo_dout),
        .full_o   (fifo_full),
        .empty_o  (fifo_empty)
    );

    // Units consume whole 4-element groups; empty or ragged rows are rejected.
    assign cmd_bad  = (op_q == OP_RSV) || (mx_q == '0) ||
                      (mx_q[1:0] != 2'b00) || (my_q == '0);
    assign unit_end = ((op_q == OP_SM) && sm_end) || ((op_q == OP_LN) && ln_end);

    always_ff @(posedge core_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_NOP;
            my_q       <= '0;
            mx_q       <= '0;
            im_q       <= '0;
            om_q       <= '0;
            ifa_q      <= '0;
            ofa_q      <= '0;
            shift_q    <= '0;
            sm_start_q <= 1'b0;
            ln_start_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            done_cnt_q <= '0;
        end else begin
            sm_start_q <= 1'b0;
            ln_start_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        {op_q, my_q, mx_q, im_q, om_q, ifa_q, ofa_q, shift_q} <= fifo_dout;
                        state_q <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (op_q == OP_NOP) begin
                        done_q     <= 1'b1;
                        done_cnt_q <= done_cnt_q + 16'd1;
                        state_q    <= ST_IDLE;
                    end else if (cmd_bad) begin
                        err_q   <= 1'b1;
                        state_q <= ST_IDLE;
                    end else begin
                        // Start is registered here so it is high during LAUNCH.
                        sm_start_q <= (op_q == OP_SM);
                        ln_start_q <= (op_q == OP_LN);
                        state_q    <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: state_q <= ST_RUN;
                ST_RUN: begin
                    if (unit_end) begin
                        done_q     <= 1'b1;
                        done_cnt_q <= done_cnt_q + 16'd1;
                        state_q    <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        gbuf_ren   = 1'b0;
        gbuf_wen   = 1'b0;
        gbuf_raddr = '0;
        gbuf_waddr = '0;
        gbuf_wdata = '0;
        if (state_q == ST_RUN) begin
            if (op_q == OP_SM) begin
                gbuf_ren   = sm_ren;
                gbuf_wen   = sm_wen;
                gbuf_raddr = sm_raddr;
                gbuf_waddr = sm_waddr;
                gbuf_wdata = sm_wdata;
            end else if (op_q == OP_LN) begin
                gbuf_ren   = ln_ren;
                gbuf_wen   = ln_wen;
                gbuf_raddr = ln_raddr;
                gbuf_waddr = ln_waddr;
                gbuf_wdata = ln_wdata;
            end
        end
    end

    // Read data goes to both units outside this block.
    logic unused_rdata;
    assign unused_rdata = ^gbuf_rdata;

    assign cmd_ready            = !fifo_full;
    assign spu_busy             = (state_q != ST_IDLE) || !fifo_empty;
    assign spu_done             = done_q;
    assign spu_err              = err_q;
    assign spu_done_cnt         = done_cnt_q;
    assign cfg_matrix_y         = my_q;
    assign cfg_matrix_x         = mx_q;
    assign cfg_im_base          = im_q;
    assign cfg_om_base          = om_q;
    assign cfg_ifm_align        = ifa_q;
    assign cfg_ofm_align        = ofa_q;
    assign cfg_shift_input      = shift_q[SHIFT_IN_LSB +: 4];
    assign cfg_exp_shift_output = shift_q[SHIFT_EXP_LSB +: 5];
    assign cfg_shift_output     = shift_q[SHIFT_OUT_LSB +: 4];
    assign sm_start             = sm_start_q;
    assign ln_start             = ln_start_q;

endmodule

// File: doc/spu_dispatch.md
Name: spu_dispatch

Overview:
- Command front-end for the SPU, sitting directly upstream of the softmax unit (spu_sm_top) and the layernorm unit.
- Accepts SPU commands over a valid/ready interface and buffers them in a small FIFO.
- Launches one unit at a time with a start pulse and latched, stable configuration, then waits for that unit's end pulse.
- Owns the shared gbuf port and muxes it to the active unit; reports done/error status upstream.

Parameters:
ADDR_WIDTH, 12, gbuf address and matrix-dimension width
DATA_WIDTH, 32, gbuf data width
CMD_DEPTH, 2, command FIFO depth (power of two, >=2)

Ports:
core_clk  in  1  process clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command valid
cmd_ready  out  1  FIFO not full
cmd_op  in  2  0=NOP, 1=SM, 2=LN, 3=reserved
cmd_matrix_y / cmd_matrix_x  in  ADDR_WIDTH each  rows / row length in elements
cmd_im_base / cmd_om_base  in  ADDR_WIDTH each  input / output base address
cmd_ifm_align / cmd_ofm_align  in  ADDR_WIDTH each  row strides
cmd_shift  in  13  {shift_input[3:0], exp_shift_output[4:0], shift_output[3:0]}
spu_busy  out  1  a unit is running or the FIFO is non-empty
spu_done  out  1  one-cycle pulse when a command completes
spu_err  out  1  one-cycle pulse when a command is rejected
spu_done_cnt  out  16  completed-command count, wraps
cfg_matrix_y, cfg_matrix_x, cfg_im_base, cfg_om_base, cfg_ifm_align, cfg_ofm_align  out  ADDR_WIDTH each  latched configuration to both units
cfg_shift_input / cfg_exp_shift_output / cfg_shift_output  out  4/5/4  latched shifts
sm_start / ln_start  out  1 each  unit start pulses
sm_end / ln_end  in  1 each  unit end pulses
sm_ren / sm_wen, ln_ren / ln_wen  in  1 each  unit gbuf enables
sm_raddr / sm_waddr, ln_raddr / ln_waddr  in  ADDR_WIDTH each  unit addresses
sm_wdata / ln_wdata  in  DATA_WIDTH each  unit write data
gbuf_ren / gbuf_wen  out  1 each  to gbuf
gbuf_raddr / gbuf_waddr  out  ADDR_WIDTH each  to gbuf
gbuf_wdata  out  DATA_WIDTH  to gbuf
gbuf_rdata  in  DATA_WIDTH  from gbuf, broadcast to both units externally

Behaviour:
- Reset values: all pulses and enables 0; cfg_* 0; spu_done_cnt 0; FIFO empty (cmd_ready 1); state IDLE.
- FIFO:
  - Push on cmd_valid && cmd_ready; cmd_ready = !full.
  - Simultaneous push and pop while full is not accepted, because cmd_ready is low when full.
  - Pointers wrap modulo CMD_DEPTH.
- State machine (one-hot-free encoding, 2 bits): IDLE, CHECK, LAUNCH, RUN.
- IDLE: FIFO non-empty -> pop the head into cfg registers, go to CHECK.
- CHECK (1 cycle):
  - op==0 -> spu_done pulse, go to IDLE.
  - op==3, matrix_x==0, matrix_x[1:0]!=0, or matrix_y==0 -> spu_err pulse, go to IDLE; done count is not incremented.
  - Otherwise go to LAUNCH.
- LAUNCH (1 cycle): assert sm_start or ln_start according to op, go to RUN. cfg_* stay constant from CHECK until the RUN exit.
- RUN:
  - The selected unit's ren/raddr/wen/waddr/wdata drive gbuf_*. The other unit's requests are ignored.
  - On the selected unit's end pulse: spu_done=1 the next cycle, spu_done_cnt++, go to IDLE.
  - The non-selected unit's end pulse is ignored.
- Outside RUN: gbuf_ren=gbuf_wen=0; addresses and data are don't-care and driven 0.
- Latency:
  - A command into an empty idle block gives a start pulse 3 cycles after the push edge (pop, CHECK, LAUNCH).
  - Back-to-back commands: the next start pulse comes 3 cycles after the end pulse.
- spu_busy = (state != IDLE) || !empty.
- Asynchronous reset mid-RUN: return to IDLE and flush the FIFO. The unit is reset by the same rst_n.

Decomposition:
- Package spu_pkg holds:
  - opcode localparams OP_NOP/OP_SM/OP_LN/OP_RSV;
  - dispatcher state encodings;
  - the shift-field bit offsets of cmd_shift.
- One sub-module, spu_cmd_fifo: parameterised width/depth, synchronous push/pop, full/empty flags, async reset.
- The gbuf mux is kept inline.

Test Plan:
- SM command (y=2, x=8, im_base=0x010, om_base=0x100, aligns=2) into an idle block:
  - sm_start one cycle, 3 cycles after the push;
  - cfg_matrix_x=8 held through RUN;
  - sm_ren/raddr appear on gbuf_*;
  - sm_end -> spu_done next cycle, spu_done_cnt=1.
- Push SM, then LN, then a third command:
  - cmd_ready drops after two pushes while SM runs;
  - ln_start comes 3 cycles after sm_end;
  - the third command is accepted after the pop.
- op=3, or x=6 (not a multiple of 4):
  - spu_err pulse, no start pulse, spu_done_cnt unchanged;
  - a following valid command still runs.
- LN running while sm_wen=1 is driven with junk: gbuf_wen follows ln_wen only; a stray sm_end does not complete the command.
- rst_n asserted mid-RUN with one command queued: all outputs reach reset values immediately; the queued command never launches after release.
- NOP command: spu_done pulse at CHECK+1, no start pulse, count increments.
